multicycle_control: RTL and testbench

Main control FSM for the multi-cycle CPU core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable. It produces the 3-bit `AluOP` consumed by the ALU control stage, which merges it with `Func` to select the ALU operation. It also handles memory wait states, flags each instruction retirement, and traps on illegal opcodes.

---
 rtl/cpu_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/opcode_class_decode.sv | 46 ++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared encodings for the multi-cycle CPU control path.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_ADDR    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4,
    CLS_IALU = 3'd5,
    CLS_ILL  = 3'd6
  } iclass_e;

  localparam logic [5:0] C_OP_R    = 6'b000000;
  localparam logic [5:0] C_OP_LW   = 6'b100011;
  localparam logic [5:0] C_OP_SW   = 6'b101011;
  localparam logic [5:0] C_OP_BEQ  = 6'b000100;
  localparam logic [5:0] C_OP_J    = 6'b000010;
  localparam logic [5:0] C_OP_ADDI = 6'b001000;
  localparam logic [5:0] C_OP_ANDI = 6'b001100;
  localparam logic [5:0] C_OP_ORI  = 6'b001101;
  localparam logic [5:0] C_OP_SLTI = 6'b001010;

  localparam logic [2:0] C_ALUOP_ADD = 3'b000;
  localparam logic [2:0] C_ALUOP_BEQ = 3'b001;
  localparam logic [2:0] C_ALUOP_R   = 3'b010;
  localparam logic [2:0] C_ALUOP_AND = 3'b100;
  localparam logic [2:0] C_ALUOP_OR  = 3'b101;
  localparam logic [2:0] C_ALUOP_SLT = 3'b111;

  localparam logic [1:0] C_SRCB_REG    = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR   = 2'b01;
  localparam logic [1:0] C_SRCB_IMM    = 2'b10;
  localparam logic [1:0] C_SRCB_BRANCH = 2'b11;

  localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Control-to-datapath bundle; master = control FSM side.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic [2:0] AluOP;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       ImmZext;
  logic [1:0] PcSource;
  logic       PcWrite;
  logic       PcWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IrWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       Retire;
  logic       Illegal;

  modport master (
    input  Opcode, mem_ready,
    output AluOP, AluSrcA, AluSrcB, ImmZext, PcSource, PcWrite, PcWriteCond,
           IorD, MemRead, MemWrite, IrWrite, RegWrite, RegDst, MemToReg,
           Retire, Illegal
  );

  modport slave (
    output Opcode, mem_ready,
    input  AluOP, AluSrcA, AluSrcB, ImmZext, PcSource, PcWrite, PcWriteCond,
           IorD, MemRead, MemWrite, IrWrite, RegWrite, RegDst, MemToReg,
           Retire, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/opcode_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_class_decode
// Brief    : Maps an opcode to its instruction class, I-ALU AluOP and ImmZext.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output iclass_e    class_o,
  output logic [2:0] alu_op_o,
  output logic       imm_zext_o
);

  always_comb begin
    class_o    = CLS_ILL;
    alu_op_o   = C_ALUOP_ADD;
    imm_zext_o = 1'b0;
    case (opcode_i)
      C_OP_R:    class_o = CLS_R;
      C_OP_LW:   class_o = CLS_LW;
      C_OP_SW:   class_o = CLS_SW;
      C_OP_BEQ:  class_o = CLS_BEQ;
      C_OP_J:    class_o = CLS_J;
      C_OP_ADDI: class_o = CLS_IALU;
      C_OP_ANDI: begin
        class_o    = CLS_IALU;
        alu_op_o   = C_ALUOP_AND;
        imm_zext_o = 1'b1;
      end
      C_OP_ORI: begin
        class_o    = CLS_IALU;
        alu_op_o   = C_ALUOP_OR;
        imm_zext_o = 1'b1;
      end
      C_OP_SLTI: begin
        class_o  = CLS_IALU;
        alu_op_o = C_ALUOP_SLT;
      end
      default: class_o = CLS_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM sequencing fetch/decode/execute/memory/writeback.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  state_e     state_q, state_d;
  state_e     w_state;
  logic       w_ready;

  iclass_e    w_class;
  logic [2:0] w_alu_op;
  logic       w_imm_zext;

  iclass_e    class_q;
  logic [2:0] alu_op_q;
  logic       imm_zext_q;

  opcode_class_decode u_decode (
    .opcode_i   (bus.Opcode),
    .class_o    (w_class),
    .alu_op_o   (w_alu_op),
    .imm_zext_o (w_imm_zext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode is only trusted in DECODE; later states use this captured copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      class_q    <= CLS_ILL;
      alu_op_q   <= C_ALUOP_ADD;
      imm_zext_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      class_q    <= w_class;
      alu_op_q   <= w_alu_op;
      imm_zext_q <= w_imm_zext;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (w_class)
          CLS_R:           state_d = S_EXEC_R;
          CLS_LW, CLS_SW:  state_d = S_ADDR;
          CLS_BEQ:         state_d = S_BRANCH;
          CLS_J:           state_d = S_JUMP;
          CLS_IALU:        state_d = S_EXEC_I;
          default:         state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      S_ADDR:   state_d = (class_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // During reset the outputs decode as FETCH with no memory completion seen,
  // so only MemRead can be active and any in-flight write is dropped at once.
  assign w_state = reset ? S_FETCH : state_q;
  assign w_ready = bus.mem_ready & ~reset;

  always_comb begin
    bus.AluOP       = C_ALUOP_ADD;
    bus.AluSrcA     = 1'b0;
    bus.AluSrcB     = C_SRCB_REG;
    bus.ImmZext     = 1'b0;
    bus.PcSource    = C_PCSRC_ALU;
    bus.PcWrite     = 1'b0;
    bus.PcWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IrWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.Retire      = 1'b0;
    bus.Illegal     = 1'b0;
    case (w_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.AluSrcB = C_SRCB_FOUR;
        bus.IrWrite = w_ready;
        bus.PcWrite = w_ready;
      end
      S_DECODE: bus.AluSrcB = C_SRCB_BRANCH;
      S_EXEC_R: begin
        bus.AluSrcA = 1'b1;
        bus.AluOP   = C_ALUOP_R;
      end
      S_WB_R: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_EXEC_I: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = C_SRCB_IMM;
        bus.ImmZext = imm_zext_q;
        bus.AluOP   = alu_op_q;
      end
      S_WB_I: begin
        bus.RegWrite = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_ADDR: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = C_SRCB_IMM;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.Retire   = w_ready;
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        bus.Retire   = 1'b1;
      end
      S_BRANCH: begin
        bus.AluSrcA     = 1'b1;
        bus.AluOP       = C_ALUOP_BEQ;
        bus.PcWriteCond = 1'b1;
        bus.PcSource    = C_PCSRC_ALUOUT;
        bus.Retire      = 1'b1;
      end
      S_JUMP: begin
        bus.PcWrite  = 1'b1;
        bus.PcSource = C_PCSRC_JUMP;
        bus.Retire   = 1'b1;
      end
      S_TRAP:  bus.Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Randomized self-checking bench with a per-instruction cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector bit masks, LSB first.
  localparam int B_ILL  = 1 << 0;
  localparam int B_RET  = 1 << 1;
  localparam int B_M2R  = 1 << 2;
  localparam int B_RDST = 1 << 3;
  localparam int B_RW   = 1 << 4;
  localparam int B_IRW  = 1 << 5;
  localparam int B_MW   = 1 << 6;
  localparam int B_MR   = 1 << 7;
  localparam int B_IORD = 1 << 8;
  localparam int B_PCWC = 1 << 9;
  localparam int B_PCW  = 1 << 10;
  localparam int B_ZEXT = 1 << 13;
  localparam int B_SRCA = 1 << 16;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_IALU = 5, K_ILL = 6;

  typedef struct {
    bit         rst;
    bit         mr;
    bit         dec;
    logic [5:0] op;
    logic [31:0] exp;
  } step_t;

  step_t q[$];
  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;
  int obs_ret  = 0;
  int step_no  = 0;

  function automatic int pcs(input int v);  return v << 11; endfunction
  function automatic int srcb(input int v); return v << 14; endfunction
  function automatic int aop(input int v);  return v << 17; endfunction

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return K_IALU;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int ialu_aop(input logic [5:0] op);
    case (op)
      6'b001100: return 4;
      6'b001101: return 5;
      6'b001010: return 7;
      default:   return 0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit rst, input bit mr, input bit dec,
                      input logic [5:0] op, input int exp);
    step_t s;
    s.rst = rst; s.mr = mr; s.dec = dec; s.op = op; s.exp = exp;
    q.push_back(s);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction from the opcode table.
  task automatic build(input logic [5:0] op, input int sf, input int sm);
    int k;
    int fetch_v;
    k = kind_of(op);
    fetch_v = B_MR | srcb(1);
    repeat (sf) push(0, 0, 0, op, fetch_v);
    push(0, 1, 0, op, fetch_v | B_IRW | B_PCW);
    push(0, rnd_bit(), 1, op, srcb(3));
    case (k)
      K_R: begin
        push(0, rnd_bit(), 0, op, B_SRCA | srcb(0) | aop(2));
        push(0, rnd_bit(), 0, op, B_RW | B_RDST | B_RET);
      end
      K_IALU: begin
        push(0, rnd_bit(), 0, op, B_SRCA | srcb(2) | aop(ialu_aop(op)) |
             ((op == 6'b001100 || op == 6'b001101) ? B_ZEXT : 0));
        push(0, rnd_bit(), 0, op, B_RW | B_RET);
      end
      K_LW: begin
        push(0, rnd_bit(), 0, op, B_SRCA | srcb(2));
        repeat (sm) push(0, 0, 0, op, B_MR | B_IORD);
        push(0, 1, 0, op, B_MR | B_IORD);
        push(0, rnd_bit(), 0, op, B_RW | B_M2R | B_RET);
      end
      K_SW: begin
        push(0, rnd_bit(), 0, op, B_SRCA | srcb(2));
        repeat (sm) push(0, 0, 0, op, B_MW | B_IORD);
        push(0, 1, 0, op, B_MW | B_IORD | B_RET);
      end
      K_BEQ: push(0, rnd_bit(), 0, op, B_SRCA | aop(1) | B_PCWC | pcs(1) | B_RET);
      K_J:   push(0, rnd_bit(), 0, op, B_PCW | pcs(2) | B_RET);
      default: begin
        repeat (10 + $urandom_range(0, 4)) push(0, rnd_bit(), 0, op, B_ILL);
        push(1, rnd_bit(), 0, op, fetch_v);
      end
    endcase
    if (k != K_ILL) exp_ret++;
  endtask

  task automatic run_queue();
    step_t s;
    logic [31:0] obs;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset         = s.rst;
      bus.mem_ready = s.mr;
      bus.Opcode    = s.dec ? s.op : 6'($urandom);
      #1;
      obs = {12'd0, bus.AluOP, bus.AluSrcA, bus.AluSrcB, bus.ImmZext, bus.PcSource,
             bus.PcWrite, bus.PcWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IrWrite, bus.RegWrite, bus.RegDst, bus.MemToReg, bus.Retire,
             bus.Illegal};
      if (bus.Retire) obs_ret++;
      check_eq($sformatf("step%0d_op%b_rst%0d", step_no, s.op, s.rst), obs, s.exp);
      step_no++;
    end
  endtask

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                6'b001000, 6'b001100, 6'b001101, 6'b001010};

  initial begin
    logic [5:0] op;
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.Opcode    = 6'd0;

    push(1, 1, 0, 6'd0, B_MR | srcb(1));
    push(1, 0, 0, 6'd0, B_MR | srcb(1));

    build(6'b000000, 0, 0);
    build(6'b100011, 0, 2);
    build(6'b001101, 0, 0);
    build(6'b001010, 1, 0);
    build(6'b000100, 0, 0);
    build(6'b000010, 0, 0);

    // sw aborted by reset on its second MEM_WR stall cycle.
    build(6'b101011, 0, 3);
    repeat (3) void'(q.pop_back());
    push(1, 0, 0, 6'b101011, B_MR | srcb(1));
    exp_ret--;

    build(6'b111111, 0, 0);
    run_queue();

    for (int i = 0; i < 40; i++) begin
      build(legal_ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2));
    end
    do op = 6'($urandom); while (kind_of(op) != K_ILL);
    build(op, $urandom_range(0, 2), 0);
    build(legal_ops[$urandom_range(0, 8)], 0, 1);
    run_queue();

    check_eq("retire_count", 32'(obs_ret), 32'(exp_ret));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
